// File: rtl/cvxif_offload_scheduler.sv
// CV-X-IF offload scheduler: tracks offloaded instructions by ID from issue
// through commit/kill to result, throttles issue and drops stray results.
module cvxif_offload_scheduler #(
   parameter int ID_W            = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   flush_i,
   input  logic                                   core_issue_valid_i,
   output logic                                   core_issue_ready_o,
   input  logic [ID_W-1:0]                        core_issue_id_i,
   output logic                                   cop_issue_valid_o,
   input  logic                                   cop_issue_ready_i,
   input  logic                                   cop_issue_accept_i,
   input  logic                                   cop_issue_writeback_i,
   input  logic                                   core_commit_valid_i,
   input  logic [ID_W-1:0]                        core_commit_id_i,
   input  logic                                   core_commit_kill_i,
   input  logic                                   cop_result_valid_i,
   output logic                                   cop_result_ready_o,
   input  logic [ID_W-1:0]                        cop_result_id_i,
   output logic                                   core_result_valid_o,
   input  logic                                   core_result_ready_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   busy_o,
   output logic                                   err_o
);

   localparam int M     = MAX_OUTSTANDING;
   localparam int CNT_W = $clog2(M+1);
   localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

   logic [M-1:0]           vld_q, vld_d, wb_q, wb_d, cmt_q, cmt_d;
   logic [M-1:0][ID_W-1:0] id_q, id_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic [M-1:0]           iss_hit, cm_hit, rs_hit, free_m;
   logic [IDX_W-1:0]       free_idx;
   logic                   blk, res_ok, res_fire, alloc_en;

   always_comb begin
      for (int i = 0; i < M; i++) begin
         iss_hit[i] = vld_q[i] && (id_q[i] == core_issue_id_i);
         cm_hit[i]  = vld_q[i] && (id_q[i] == core_commit_id_i);
         rs_hit[i]  = vld_q[i] && wb_q[i] && cmt_q[i] && (id_q[i] == cop_result_id_i);
      end
      free_idx = '0;
      for (int i = M-1; i >= 0; i--)
         if (!vld_q[i]) free_idx = IDX_W'(i);
   end

   // Full is taken from registered state only: a same-cycle free never unblocks issue.
   assign blk                 = (&vld_q) | (|iss_hit) | flush_i;
   assign cop_issue_valid_o   = core_issue_valid_i & ~blk;
   assign core_issue_ready_o  = cop_issue_ready_i & ~blk;
   assign alloc_en            = cop_issue_valid_o & cop_issue_ready_i & cop_issue_accept_i;

   // Only committed writeback entries forward; everything else is swallowed.
   assign res_ok              = (|rs_hit) & ~flush_i;
   assign core_result_valid_o = cop_result_valid_i & res_ok;
   assign cop_result_ready_o  = res_ok ? core_result_ready_i : 1'b1;
   assign res_fire            = cop_result_valid_i & res_ok & core_result_ready_i;

   always_comb begin
      vld_d  = vld_q;
      wb_d   = wb_q;
      cmt_d  = cmt_q;
      id_d   = id_q;
      err_d  = err_q;
      free_m = '0;
      cnt_d  = '0;

      if (core_commit_valid_i) begin
         if (|cm_hit) begin
            for (int i = 0; i < M; i++) begin
               if (cm_hit[i]) begin
                  if (core_commit_kill_i || !wb_q[i]) free_m[i] = 1'b1;
                  else                                cmt_d[i]  = 1'b1;
                  if (res_fire && rs_hit[i])          err_d     = 1'b1;
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end

      if (res_fire) free_m = free_m | rs_hit;
      if (cop_result_valid_i && !res_ok && !flush_i) err_d = 1'b1;

      vld_d = vld_q & ~free_m;
      if (alloc_en) begin
         vld_d[free_idx] = 1'b1;
         id_d[free_idx]  = core_issue_id_i;
         wb_d[free_idx]  = cop_issue_writeback_i;
         cmt_d[free_idx] = 1'b0;
      end
      if (flush_i) vld_d = '0;

      for (int i = 0; i < M; i++) cnt_d = cnt_d + CNT_W'(vld_d[i]);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_q <= '0;
         wb_q  <= '0;
         cmt_q <= '0;
         id_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         wb_q  <= wb_d;
         cmt_q <= cmt_d;
         id_q  <= id_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign outstanding_o = cnt_q;
   assign busy_o        = (cnt_q != '0);
   assign err_o         = err_q;

endmodule

// File: tb/tb_cvxif_offload_scheduler.sv
// Directed bench for cvxif_offload_scheduler: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_cvxif_offload_scheduler;

   localparam int ID_W = 3;
   localparam int M    = 4;
   localparam int CW   = $clog2(M+1);

   localparam int F_IRDY = 0, F_CIV = 1, F_CRR = 2, F_CRV = 3, F_OUT = 4, F_BUSY = 5, F_ERR = 6;

   logic            clk = 1'b0;
   logic            rst_n, flush;
   logic            civ, irdy, cop_iv, cop_rdy, acc, wbk;
   logic [ID_W-1:0] iid, cid, rid;
   logic            cmv, kill, crv, crr, core_rv, core_rr;
   logic [CW-1:0]   outst;
   logic            busy, err;

   cvxif_offload_scheduler #(.ID_W(ID_W), .MAX_OUTSTANDING(M)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .core_issue_valid_i(civ), .core_issue_ready_o(irdy), .core_issue_id_i(iid),
      .cop_issue_valid_o(cop_iv), .cop_issue_ready_i(cop_rdy),
      .cop_issue_accept_i(acc), .cop_issue_writeback_i(wbk),
      .core_commit_valid_i(cmv), .core_commit_id_i(cid), .core_commit_kill_i(kill),
      .cop_result_valid_i(crv), .cop_result_ready_o(crr), .cop_result_id_i(rid),
      .core_result_valid_o(core_rv), .core_result_ready_i(core_rr),
      .outstanding_o(outst), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int fld; int exp; string name;} exp_t;
   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0, n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get(input int f);
      case (f)
         F_IRDY: return int'(irdy);
         F_CIV:  return int'(cop_iv);
         F_CRR:  return int'(crr);
         F_CRV:  return int'(core_rv);
         F_OUT:  return int'(outst);
         F_BUSY: return int'(busy);
         default: return int'(err);
      endcase
   endfunction

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         int   act;
         e   = q.pop_front();
         act = get(e.fld);
         n_cmp++;
         if (act != e.exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.name, cyc, act, e.exp);
         end
      end
   end

   task automatic chk(input int dly, input int f, input int v, input string nm);
      q.push_back('{cyc + dly, f, v, nm});
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int id, input logic w);
      civ = 1'b1; iid = ID_W'(id); wbk = w;
   endtask

   task automatic commit(input int id, input logic k);
      cmv = 1'b1; cid = ID_W'(id); kill = k;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; civ = 1'b1; iid = '0; cop_rdy = 1'b1; acc = 1'b1; wbk = 1'b1;
      cmv = 1'b0; cid = '0; kill = 1'b0; crv = 1'b0; rid = '0; core_rr = 1'b1;
      nxt();
      // reset state; issue gate passes straight through
      chk(0, F_OUT, 0, "rst_out"); chk(0, F_BUSY, 0, "rst_busy"); chk(0, F_ERR, 0, "rst_err");
      chk(0, F_IRDY, 1, "rst_irdy"); chk(0, F_CIV, 1, "rst_civ");
      nxt();
      rst_n = 1'b1; civ = 1'b0;
      nxt();

      // fill table with IDs 0..3, then a 5th is blocked
      for (int i = 0; i < 4; i++) begin
         issue(i, 1'b1);
         chk(0, F_IRDY, 1, "fill_irdy"); chk(0, F_CIV, 1, "fill_civ");
         nxt();
      end
      issue(4, 1'b1);
      chk(0, F_OUT, 4, "full_out"); chk(0, F_BUSY, 1, "full_busy");
      chk(0, F_IRDY, 0, "full_irdy"); chk(0, F_CIV, 0, "full_civ");
      nxt();
      civ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         commit(i, 1'b1);
         nxt();
      end
      cmv = 1'b0;
      chk(0, F_OUT, 0, "drain_out");
      nxt();

      // no-writeback instruction frees on commit
      issue(2, 1'b0);
      nxt();
      civ = 1'b0; commit(2, 1'b0);
      chk(0, F_OUT, 1, "nowb_out1");
      nxt();
      cmv = 1'b0;
      chk(0, F_OUT, 0, "nowb_out0"); chk(0, F_ERR, 0, "nowb_err");
      nxt();

      // result during flush is dropped silently
      flush = 1'b1; crv = 1'b1; rid = 3'd7;
      chk(0, F_CRR, 1, "flush_crr"); chk(0, F_CRV, 0, "flush_crv"); chk(1, F_ERR, 0, "flush_err");
      nxt();
      flush = 1'b0; crv = 1'b0;

      // killed instruction's result is stray
      issue(5, 1'b1);
      nxt();
      civ = 1'b0; commit(5, 1'b1);
      nxt();
      cmv = 1'b0; crv = 1'b1; rid = 3'd5;
      chk(0, F_CRR, 1, "kill_crr"); chk(0, F_CRV, 0, "kill_crv"); chk(0, F_ERR, 0, "kill_err0");
      chk(1, F_ERR, 1, "kill_err1");
      nxt();
      crv = 1'b0;

      // result backpressured for 3 cycles
      issue(1, 1'b1);
      nxt();
      civ = 1'b0; commit(1, 1'b0);
      nxt();
      cmv = 1'b0; crv = 1'b1; rid = 3'd1; core_rr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk(0, F_CRR, 0, "bp_crr"); chk(0, F_CRV, 1, "bp_crv"); chk(0, F_OUT, 1, "bp_out");
         nxt();
      end
      core_rr = 1'b1;
      chk(0, F_CRR, 1, "hs_crr"); chk(0, F_CRV, 1, "hs_crv"); chk(1, F_OUT, 0, "hs_out");
      nxt();
      crv = 1'b0;

      // full table: same-cycle result free does not unblock issue
      for (int i = 0; i < 4; i++) begin
         issue(i, 1'b1);
         nxt();
      end
      civ = 1'b0; commit(0, 1'b0);
      chk(0, F_OUT, 4, "nb_full");
      nxt();
      cmv = 1'b0; crv = 1'b1; rid = 3'd0; issue(6, 1'b1);
      chk(0, F_IRDY, 0, "nb_irdy"); chk(0, F_CIV, 0, "nb_civ");
      chk(0, F_CRR, 1, "nb_crr"); chk(0, F_CRV, 1, "nb_crv"); chk(0, F_OUT, 4, "nb_out");
      nxt();
      crv = 1'b0;
      chk(0, F_IRDY, 1, "nb2_irdy"); chk(0, F_CIV, 1, "nb2_civ"); chk(1, F_OUT, 4, "nb2_out");
      nxt();
      civ = 1'b0;

      // three live (0,2,3), flush, then reissue ID 0
      commit(6, 1'b1);
      nxt();
      commit(1, 1'b1);
      nxt();
      cmv = 1'b0; issue(0, 1'b1);
      nxt();
      flush = 1'b1;
      chk(0, F_IRDY, 0, "fl_irdy"); chk(0, F_CIV, 0, "fl_civ"); chk(0, F_OUT, 3, "fl_out3");
      chk(1, F_OUT, 0, "fl_out0"); chk(1, F_BUSY, 0, "fl_busy");
      nxt();
      flush = 1'b0;
      chk(0, F_IRDY, 1, "re_irdy"); chk(0, F_CIV, 1, "re_civ"); chk(1, F_OUT, 1, "re_out");
      nxt();
      civ = 1'b0;

      // reset mid-operation clears table and sticky error
      rst_n = 1'b0; issue(3, 1'b1);
      chk(1, F_OUT, 0, "mr_out"); chk(1, F_BUSY, 0, "mr_busy"); chk(1, F_ERR, 0, "mr_err");
      nxt();
      rst_n = 1'b1; civ = 1'b0;
      repeat (3) nxt();

      if (q.size() != 0) begin
         n_err++;
         $display("FAIL pending got=%0d exp=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
